// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer demux/mux pair.
// HDR_WIDTH    : number of header bits at the top of every word
// WORD_WIDTH   : reference word width used by hdr_dest()
// chan_t       : channel index type, CH0..CH3 channel constants
// hdr_dest()   : returns the destination channel carried in a word's header
package buffer_pkg;

  localparam int HDR_WIDTH  = 2;
  localparam int WORD_WIDTH = 40;

  typedef logic [HDR_WIDTH-1:0] chan_t;

  localparam chan_t CH0 = 2'd0;
  localparam chan_t CH1 = 2'd1;
  localparam chan_t CH2 = 2'd2;
  localparam chan_t CH3 = 2'd3;

  // Destination lives in the most significant HDR_WIDTH bits of the word.
  function automatic chan_t hdr_dest(input logic [WORD_WIDTH-1:0] word);
    return chan_t'(word[WORD_WIDTH-1 -: HDR_WIDTH]);
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO for buffer_demux.
// clk, rst_n : clock, asynchronous active-low reset
// flush      : synchronous clear of all entries (priority over push/pop)
// push       : write push_data at the tail (honoured when not full or popping)
// pop        : remove the head entry (ignored while empty)
// full/empty : occupancy flags
// head       : registered head entry; holds its last value once empty
module demux_chan_fifo #(
  parameter int DATA_WIDTH = 40,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic [AW:0]           wr_ptr_nxt_s;
  logic [AW:0]           rd_ptr_nxt_s;
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;

  // Extra wrap bit distinguishes full (wrap differs) from empty (identical).
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  assign pop_s  = pop && !empty_s;
  assign push_s = push && (!full_s || pop_s);

  // Next pointer values.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Pointer, storage and registered-head update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      head_r   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
      // Present the next head; when the new head is the word being written
      // this cycle, take it straight from push_data. Hold when going empty.
      if (wr_ptr_nxt_s != rd_ptr_nxt_s) begin
        if (push_s && (rd_ptr_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
          head_r <= push_data;
        end else begin
          head_r <= mem_r[rd_ptr_nxt_s[AW-1:0]];
        end
      end
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign head  = head_r;

endmodule

// File: rtl/buffer_demux.sv
// Routes a stream of headered words to four per-channel output FIFOs.
// clk, rst_n          : clock, asynchronous active-low reset
// in_data/valid/ready : input stream; destination in the top two bits
// flush               : synchronous clear of all channels and counters
// out_dataN/validN/readyN : per-channel drain handshake (N = 0..3)
// fwd_cntN            : words accepted into channel N since reset or flush
// All-zero words are idle filler: accepted and dropped.
module buffer_demux
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 40,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic                  out_valid0,
  output logic                  out_valid1,
  output logic                  out_valid2,
  output logic                  out_valid3,
  input  logic                  out_ready0,
  input  logic                  out_ready1,
  input  logic                  out_ready2,
  input  logic                  out_ready3,
  output logic [CNT_WIDTH-1:0]  fwd_cnt0,
  output logic [CNT_WIDTH-1:0]  fwd_cnt1,
  output logic [CNT_WIDTH-1:0]  fwd_cnt2,
  output logic [CNT_WIDTH-1:0]  fwd_cnt3
);

  logic [WORD_WIDTH-1:0] hdr_word_s;
  chan_t                 dest_s;
  logic                  is_zero_s;
  logic                  in_ready_s;
  logic [3:0]            full_s;
  logic [3:0]            empty_s;
  logic [3:0]            out_ready_s;
  logic [3:0]            pop_s;
  logic [3:0]            push_s;
  logic [DATA_WIDTH-1:0] head_s [4];
  logic [CNT_WIDTH-1:0]  cnt_r  [4];

  // Re-align the header to the reference word layout so hdr_dest() applies
  // whatever DATA_WIDTH is.
  assign hdr_word_s = {in_data[DATA_WIDTH-1 -: HDR_WIDTH],
                       {(WORD_WIDTH-HDR_WIDTH){1'b0}}};
  assign dest_s     = hdr_dest(hdr_word_s);
  assign is_zero_s  = (in_data == '0);

  assign out_ready_s = {out_ready3, out_ready2, out_ready1, out_ready0};
  assign pop_s       = ~empty_s & out_ready_s;

  // Input acceptance: filler always taken, otherwise the destination needs
  // a free slot or a same-cycle pop. Independent of in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    if (flush) begin
      in_ready_s = 1'b0;
    end else if (is_zero_s) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = !full_s[dest_s] || pop_s[dest_s];
    end
  end

  // One-hot push toward the destination channel for accepted non-zero words.
  always_comb begin
    push_s = 4'b0000;
    if (in_valid && in_ready_s && !is_zero_s) begin
      push_s[dest_s] = 1'b1;
    end else begin
      push_s = 4'b0000;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_chan
      demux_chan_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push_s[g]),
        .push_data (in_data),
        .pop       (pop_s[g]),
        .full      (full_s[g]),
        .empty     (empty_s[g]),
        .head      (head_s[g])
      );
    end
  endgenerate

  // Forwarded-word counters; wrap modulo 2^CNT_WIDTH, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_data0  = head_s[0];
  assign out_data1  = head_s[1];
  assign out_data2  = head_s[2];
  assign out_data3  = head_s[3];
  assign out_valid0 = !empty_s[0];
  assign out_valid1 = !empty_s[1];
  assign out_valid2 = !empty_s[2];
  assign out_valid3 = !empty_s[3];
  assign fwd_cnt0   = cnt_r[0];
  assign fwd_cnt1   = cnt_r[1];
  assign fwd_cnt2   = cnt_r[2];
  assign fwd_cnt3   = cnt_r[3];

endmodule

// File: tb/tb_buffer_demux.sv
// Self-checking bench for buffer_demux: directed vector table plus
// hand-written sequences for counter wrap and asynchronous reset.
module tb_buffer_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] in_data = 40'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [3:0]  rdy = 4'b0000;
  logic [39:0] od [4];
  logic [3:0]  ov;
  logic [15:0] cnt [4];

  int checks = 0;
  int errors = 0;

  buffer_demux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data0  (od[0]),
    .out_data1  (od[1]),
    .out_data2  (od[2]),
    .out_data3  (od[3]),
    .out_valid0 (ov[0]),
    .out_valid1 (ov[1]),
    .out_valid2 (ov[2]),
    .out_valid3 (ov[3]),
    .out_ready0 (rdy[0]),
    .out_ready1 (rdy[1]),
    .out_ready2 (rdy[2]),
    .out_ready3 (rdy[3]),
    .fwd_cnt0   (cnt[0]),
    .fwd_cnt1   (cnt[1]),
    .fwd_cnt2   (cnt[2]),
    .fwd_cnt3   (cnt[3])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0]      d;
    logic             v;
    logic             fl;
    logic [3:0]       rdy;
    logic             exp_rdy;
    logic [3:0]       exp_ov;
    int               ch;
    logic [39:0]      exp_od;
    logic [3:0][15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [39:0] d, input logic v, input logic fl,
                              input logic [3:0] r, input logic er, input logic [3:0] eov,
                              input int ch, input logic [39:0] eod,
                              input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
    vec_t t;
    t.d = d; t.v = v; t.fl = fl; t.rdy = r; t.exp_rdy = er; t.exp_ov = eov;
    t.ch = ch; t.exp_od = eod; t.exp_cnt = {c3, c2, c1, c0};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_cnt(input string nm, input logic [3:0][15:0] exp);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s cnt%0d", nm, c), 64'(cnt[c]), 64'(exp[c]));
    end
  endtask

  initial begin
    // d, v, fl, rdy, exp_rdy, exp_ov, ch, exp_od, cnt0..3
    // single word to channel 1, idle, filler, drain
    tbl.push_back(mk(40'h40000000AB, 1, 0, 4'b0000, 1, 4'b0010, 1, 40'h40000000AB, 0, 1, 0, 0));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b0000, 1, 4'b0010, 1, 40'h40000000AB, 0, 1, 0, 0));
    tbl.push_back(mk(40'h0000000000, 1, 0, 4'b0000, 1, 4'b0010, 0, 40'h0000000000, 0, 1, 0, 0));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b0010, 1, 4'b0000, 1, 40'h40000000AB, 0, 1, 0, 0));
    // fill channel 2, stall, channel 0 still accepted, pop frees slot
    tbl.push_back(mk(40'h8000000001, 1, 0, 4'b0000, 1, 4'b0100, 2, 40'h8000000001, 0, 1, 1, 0));
    tbl.push_back(mk(40'h8000000002, 1, 0, 4'b0000, 1, 4'b0100, 2, 40'h8000000001, 0, 1, 2, 0));
    tbl.push_back(mk(40'h8000000003, 1, 0, 4'b0000, 0, 4'b0100, 2, 40'h8000000001, 0, 1, 2, 0));
    tbl.push_back(mk(40'h0000000055, 1, 0, 4'b0000, 1, 4'b0101, 0, 40'h0000000055, 1, 1, 2, 0));
    tbl.push_back(mk(40'h8000000003, 1, 0, 4'b0100, 1, 4'b0101, 2, 40'h8000000002, 1, 1, 3, 0));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b0101, 1, 4'b0100, 2, 40'h8000000003, 1, 1, 3, 0));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b0100, 1, 4'b0000, 2, 40'h8000000003, 1, 1, 3, 0));
    // push into empty channel with ready high: becomes head, no pop
    tbl.push_back(mk(40'hC000000007, 1, 0, 4'b1000, 1, 4'b1000, 3, 40'hC000000007, 1, 1, 3, 1));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b1000, 1, 4'b0000, 3, 40'hC000000007, 1, 1, 3, 1));
    // fill channel 1 then flush with a valid input word
    tbl.push_back(mk(40'h40000000B1, 1, 0, 4'b0000, 1, 4'b0010, 1, 40'h40000000B1, 1, 2, 3, 1));
    tbl.push_back(mk(40'h40000000B2, 1, 0, 4'b0000, 1, 4'b0010, 1, 40'h40000000B1, 1, 3, 3, 1));
    tbl.push_back(mk(40'h40000000B3, 1, 1, 4'b0000, 0, 4'b0000, 1, 40'h40000000B1, 0, 0, 0, 0));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b0000, 1, 4'b0000, 1, 40'h40000000B1, 0, 0, 0, 0));
    // back-to-back round robin, all sinks ready
    tbl.push_back(mk(40'h00000000A0, 1, 0, 4'b1111, 1, 4'b0001, 0, 40'h00000000A0, 1, 0, 0, 0));
    tbl.push_back(mk(40'h40000000A1, 1, 0, 4'b1111, 1, 4'b0010, 1, 40'h40000000A1, 1, 1, 0, 0));
    tbl.push_back(mk(40'h80000000A2, 1, 0, 4'b1111, 1, 4'b0100, 2, 40'h80000000A2, 1, 1, 1, 0));
    tbl.push_back(mk(40'hC0000000A3, 1, 0, 4'b1111, 1, 4'b1000, 3, 40'hC0000000A3, 1, 1, 1, 1));
    tbl.push_back(mk(40'h00000000C0, 1, 0, 4'b1111, 1, 4'b0001, 0, 40'h00000000C0, 2, 1, 1, 1));
    tbl.push_back(mk(40'h40000000C1, 1, 0, 4'b1111, 1, 4'b0010, 1, 40'h40000000C1, 2, 2, 1, 1));
    tbl.push_back(mk(40'h80000000C2, 1, 0, 4'b1111, 1, 4'b0100, 2, 40'h80000000C2, 2, 2, 2, 1));
    tbl.push_back(mk(40'hC0000000C3, 1, 0, 4'b1111, 1, 4'b1000, 3, 40'hC0000000C3, 2, 2, 2, 2));
    tbl.push_back(mk(40'h0000000000, 0, 0, 4'b1111, 1, 4'b0000, 3, 40'hC0000000C3, 2, 2, 2, 2));

    // Reset state, checked while rst_n is still low.
    in_data = 40'h80000000FF;
    #2;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(ov), 64'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("reset out_data%0d", c), 64'(od[c]), 64'd0);
    end
    chk_all_cnt("reset", 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_data = 40'h0;

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_data = tbl[i].d;
      in_valid = tbl[i].v;
      flush = tbl[i].fl;
      rdy = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 64'(ov), 64'(tbl[i].exp_ov));
      chk($sformatf("v%0d out_data%0d", i, tbl[i].ch), 64'(od[tbl[i].ch]), 64'(tbl[i].exp_od));
      chk_all_cnt($sformatf("v%0d", i), tbl[i].exp_cnt);
    end

    // Counter wrap on channel 3: clear, 65535 words, then one more.
    @(negedge clk);
    in_valid = 1'b0;
    rdy = 4'b0000;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk_all_cnt("flush before wrap", 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_data = 40'hC000001234;
    in_valid = 1'b1;
    rdy = 4'b1000;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap cnt3 max", 64'(cnt[3]), 64'hFFFF);
    chk("wrap in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("wrap cnt3 zero", 64'(cnt[3]), 64'd0);
    chk("wrap out_valid3", 64'(ov[3]), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a burst into channel 0.
    @(negedge clk);
    rdy = 4'b0000;
    in_data = 40'h0000000011;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 40'h0000000012;
    @(negedge clk);
    in_data = 40'h0000000013;
    #1;
    chk("burst ch0 full", 64'(in_ready), 64'd0);
    chk("burst out_valid0", 64'(ov[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(ov), 64'd0);
    chk("async rst out_data0", 64'(od[0]), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    chk_all_cnt("async rst", 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst out_valid", 64'(ov), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
